instr_prefetch_queue: RTL
=========================

Name: instr_prefetch_queue

Overview:
- Sits between the instruction memory and the decoder. Replaces direct fetch-to-decoder wiring with a small prefetch FIFO.
- Issues sequential instruction-memory reads ahead of consumption and buffers {pc, instruction} pairs. Presents them to the decoder with a valid/ready handshake.
- Flushes and redirects on a taken branch from the ALU jump path.

Parameters:
- instr_width, 9, instruction word width
- pc_width, 9, instruction address width
- depth, 4, FIFO entries (power of two, >= 2)

Ports:
- clk  input  1  clock, all state on posedge
- start  input  1  synchronous active-high reset; also loads start_addr
- start_addr  input  pc_width  PC loaded while start=1
- halt  input  1  stop issuing new memory reads
- branch_taken  input  1  redirect request, valid for one cycle
- branch_target  input  pc_width  redirect PC (zero-extended by the driver from reg_width)
- imem_req  output  1  read request this cycle
- imem_addr  output  pc_width  read address, valid when imem_req=1
- imem_valid  input  1  read data valid; fixed 1-cycle latency after imem_req
- imem_data  input  instr_width  read data
- instr_valid  output  1  head entry available
- instr_ready  input  1  decoder accepts head this cycle
- instr_out  output  instr_width  head instruction
- instr_pc  output  pc_width  PC of head instruction
- flush_cnt  output  8  number of redirects, saturating at 255

Behaviour:
- Reset (start=1, priority over everything):
  - fetch_pc <= start_addr; FIFO count <= 0; inflight <= 0; kill <= 0; flush_cnt <= 0.
  - imem_req=0, instr_valid=0, instr_out=0, instr_pc=0.
- Issue:
  - Condition: imem_req = !start && !halt && !branch_taken && (count + inflight < depth).
  - imem_req is combinational from registered state plus halt/branch_taken/start.
  - imem_addr = fetch_pc. On issue, fetch_pc <= fetch_pc+1, wrapping mod 2^pc_width (511 -> 0).
  - inflight <= imem_req. Issued PC is registered as the response tag.
- Response:
  - In the cycle after an issue, imem_valid=1 pushes {tag_pc, imem_data} unless kill=1.
  - imem_valid without a preceding issue is a protocol error; the bench asserts on it.
- Dequeue:
  - instr_valid = (count != 0). instr_out and instr_pc come from the head entry (registered storage).
  - Pop when instr_valid && instr_ready. instr_ready while instr_valid=0 is ignored.
- Push and pop in the same cycle: count unchanged. Legal even at count=depth-1 with inflight=1; the space reservation guarantees no overflow.
- Latency: start deasserts in cycle 0 -> imem_req=1 with addr=start_addr in cycle 0 -> imem_valid in cycle 1 -> instr_valid=1 in cycle 2. Steady state: 1 instruction/cycle with instr_ready held high.
- Redirect (branch_taken=1), priority over push/pop/issue:
  - Next cycle: count=0, fetch_pc=branch_target.
  - A request in flight from the redirect cycle is marked kill; its response is dropped.
  - No issue in the redirect cycle. The first target request issues the cycle after; its instr_valid follows 2 cycles later.
  - A pop coinciding with branch_taken counts as consumed (it is the branch itself). flush_cnt increments, saturating.
- Halt:
  - New issues stop. An in-flight response is still enqueued. The FIFO still drains to the decoder.
  - Deasserting halt resumes issuing at fetch_pc.
  - branch_taken during halt still flushes and redirects.
- Full: no issue while count+inflight=depth. Empty: instr_valid=0 and head outputs hold their last value.
- Start mid-operation discards all entries and in-flight data in the same edge.

Decomposition:
- Package prefetch_pkg:
  - localparams DEPTH=4, PC_W=9, INSTR_W=9.
  - typedef struct packed {logic [PC_W-1:0] pc; logic [INSTR_W-1:0] instr;} pf_entry_t.
  - typedef for the count width: $clog2(DEPTH)+1 bits.
- One sub-module, pf_fifo: synchronous FIFO of pf_entry_t with push, pop and flush inputs, head, count, full and empty outputs.
- Flush has priority over push and pop inside pf_fifo. Read/write pointers wrap mod DEPTH.

Test Plan:
- start=1 with start_addr=0x010, then release with instr_ready=1 -> imem_addr 0x010,0x011,... on consecutive cycles; instr_valid first high 2 cycles after release; instr_pc sequence 0x010,0x011,0x012 matching the memory model data.
- instr_ready=0 for 10 cycles -> imem_req stops after exactly 4 issues; count=4. Raising instr_ready drains 0x010..0x013 in order, then issuing resumes at 0x014.
- branch_taken with branch_target=0x080 while 3 entries are queued and 1 in flight -> next cycle instr_valid=0; the in-flight response is dropped; the next valid instr_pc=0x080; flush_cnt=1.
- start_addr=0x1FE, free-run -> instr_pc 0x1FE,0x1FF,0x000 (wrap).
- halt=1 with 1 in flight and 2 queued -> exactly 3 more instructions delivered, then instr_valid=0; imem_req stays 0 until halt=0, then the next addr is the one following the last issued.
- 300 redirects -> flush_cnt saturates at 255. start pulsed mid-stream -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/prefetch_pkg.sv
// Shared sizing and types for the instruction prefetch queue.
package prefetch_pkg;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PC_W    = 9;
  localparam int unsigned INSTR_W = 9;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } pf_entry_t;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // Entries buffered plus the read still owed by memory.
  function automatic cnt_t occupancy(input cnt_t count, input logic inflight);
    return count + cnt_t'(inflight);
  endfunction

endpackage

// File: rtl/pf_fifo.sv
// Synchronous FIFO of {pc, instr} entries. Flush beats push/pop; the head
// output keeps showing the last presented entry while the FIFO is empty.
module pf_fifo
  import prefetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  pf_entry_t wdata,
  output pf_entry_t head,
  output cnt_t      count,
  output logic      full,
  output logic      empty
);

  pf_entry_t mem [DEPTH];
  ptr_t      rptr_q;
  ptr_t      wptr_q;
  cnt_t      count_q;
  pf_entry_t hold_q;
  logic      do_push;
  logic      do_pop;

  // Status, gated handshakes and head selection.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == cnt_t'(DEPTH));
    do_pop  = pop && !empty;
    // A write into a full FIFO is only safe when the head leaves in the same cycle.
    do_push = push && (!full || do_pop);
    head    = empty ? hold_q : mem[rptr_q];
    count   = count_q;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + ptr_t'(1);
      if (do_pop)  rptr_q <= rptr_q + ptr_t'(1);
      count_q <= count_q + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end

  // Remember what is shown so an empty FIFO keeps presenting it.
  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= head;
  end

  // Entry storage, no reset needed: reads are masked by count.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Prefetch queue between instruction memory and decoder. Issues sequential
// reads while there is reserved space, buffers {pc, instr} pairs and flushes
// and redirects on a taken branch. Sizing comes from prefetch_pkg.
module instr_prefetch_queue
  import prefetch_pkg::*;
(
  input  logic               clk,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  input  logic               halt,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  output logic [7:0]         flush_cnt
);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] tag_pc_q, tag_pc_d;
  logic            inflight_q;
  logic            kill_q;
  logic [7:0]      flush_cnt_q, flush_cnt_d;

  logic      fifo_push;
  pf_entry_t fifo_wdata;
  pf_entry_t fifo_head;
  cnt_t      fifo_count;
  logic      fifo_full;
  logic      fifo_empty;

  // Issue decision counts the in-flight read so its response always has a slot.
  always_comb begin
    imem_req  = !start && !halt && !branch_taken && !fifo_full &&
                (occupancy(fifo_count, inflight_q) < cnt_t'(DEPTH));
    imem_addr = fetch_pc_q;
  end

  // Response capture and decoder-facing outputs.
  always_comb begin
    // Responses landing in a redirect cycle, or in the slot right after one, are stale.
    fifo_push   = imem_valid && inflight_q && !kill_q && !branch_taken;
    fifo_wdata  = '{pc: tag_pc_q, instr: imem_data};
    instr_valid = !fifo_empty;
    instr_out   = fifo_head.instr;
    instr_pc    = fifo_head.pc;
    flush_cnt   = flush_cnt_q;
  end

  // Next fetch PC, response tag and saturating redirect counter.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    tag_pc_d    = tag_pc_q;
    flush_cnt_d = flush_cnt_q;
    if (branch_taken) begin
      fetch_pc_d = branch_target;
      if (flush_cnt_q != 8'hFF) flush_cnt_d = flush_cnt_q + 8'd1;
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + PC_W'(1);
      tag_pc_d   = fetch_pc_q;
    end
  end

  // Control state; start doubles as synchronous reset.
  always_ff @(posedge clk) begin
    if (start) begin
      fetch_pc_q  <= start_addr;
      tag_pc_q    <= '0;
      inflight_q  <= 1'b0;
      kill_q      <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      tag_pc_q    <= tag_pc_d;
      inflight_q  <= imem_req;
      kill_q      <= branch_taken;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  pf_fifo u_fifo (
    .clk   (clk),
    .rst   (start),
    .push  (fifo_push),
    .pop   (instr_ready),
    .flush (branch_taken),
    .wdata (fifo_wdata),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
